pipe_ctrl_gen: RTL and testbench
================================

Name: pipe_ctrl_gen

Overview:
Parametrised successor to the core pipeline control unit. It arbitrates NUM_JSRC jump/redirect requesters and combines EX/CLINT/HDU stall sources into per-stage stall and flush vectors. It adds three behaviours the previous unit lacks: a pending-redirect buffer (jumps blocked by a hard stall or atomic op are held, not dropped), a multi-cycle flush window, and a stall watchdog. It sits between EX/CLINT/HDU and pc_reg plus the pipeline stage registers.

Parameters:
ADDR_W, 32, instruction address width
NUM_JSRC, 2, number of jump requesters; index 0 has highest priority
NUM_STAGES, 4, pipeline stages driven (0=IF, ascending toward EX)
HDU_STAGE, 1, highest stage index stalled by a data-hazard stall
FLUSH_LEN, 1, cycles flush_o stays asserted per redirect (range 1..15)
WDT_W, 16, watchdog counter width

Ports:
clk  in  1  core clock
rst  in  1  asynchronous, active-high reset
jump_req_i  in  NUM_JSRC  per-source jump request
jump_addr_i  in  NUM_JSRC*ADDR_W  per-source target; source k occupies bits [k*ADDR_W +: ADDR_W]
stall_ex_i  in  1  EX stall (hard)
stall_clint_i  in  1  CLINT stall (hard)
stall_hdu_i  in  1  data-hazard stall
atom_busy_i  in  1  atomic op in flight; blocks redirect
flush_clint_i  in  1  interrupt flush
wdt_limit_i  in  WDT_W  watchdog limit; 0 disables the watchdog
wdt_clr_i  in  1  clears wdt_expired_o
stall_o  out  NUM_STAGES  per-stage stall
flush_o  out  NUM_STAGES  per-stage flush
jump_flag_o  out  1  redirect strobe to pc_reg
jump_addr_o  out  ADDR_W  redirect target
jump_pending_o  out  1  a blocked redirect is held
wdt_expired_o  out  1  sticky stall-timeout flag

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; pending valid/addr=0; flush counter=0; watchdog=0.
  - All outputs 0.
- hard = stall_ex_i | stall_clint_i.
- block = hard | atom_busy_i.
- Arbitration: sel = lowest-index asserted jump_req_i bit; req_any = |jump_req_i.
- IDLE:
  - req_any & ~block & ~flush_clint_i: jump_flag_o=1 and jump_addr_o=addr[sel] in the same cycle (0 latency). Go to FLUSH with count=FLUSH_LEN-1 if FLUSH_LEN>1, else stay in IDLE.
  - req_any & block & ~flush_clint_i: capture addr[sel] into the pending register; go to HOLD; jump_flag_o=0.
- HOLD:
  - jump_pending_o=1.
  - All jump_req_i are ignored; the held redirect is the oldest and wins.
  - When ~block: jump_flag_o=1 with jump_addr_o=pend_addr; clear pending; enter FLUSH/IDLE as in IDLE.
- FLUSH:
  - flush_o all-ones; jump_req_i ignored (wrong-path).
  - Counter decrements each cycle; at 0 return to IDLE.
- flush_clint_i in any state:
  - Forces jump_flag_o=0 and clears pending.
  - Next state is IDLE.
  - flush_o all-ones in that cycle.
- flush_o = all-ones when (jump_flag_o | flush_clint_i | state==FLUSH); otherwise 0.
- stall_o[s] = hard | (stall_hdu_i & ~jump_flag_o & s<=HDU_STAGE).
  - stall_o is not masked by flush_o; stage registers give flush priority.
- jump_addr_o = 0 whenever jump_flag_o=0.
- Watchdog:
  - Counter increments while (hard | stall_hdu_i), saturates at all-ones, and clears on any stall-free cycle.
  - When wdt_limit_i!=0 and count==wdt_limit_i, wdt_expired_o is set on the next edge.
  - wdt_expired_o stays set until wdt_clr_i=1; clear has priority over a simultaneous set.
- Simultaneous events:
  - Pending release and hard stall reasserting in the same cycle: release is blocked and HOLD is kept.
  - rst mid-HOLD: pending redirect discarded.

Decomposition:
- Package pipe_ctrl_pkg: state enum (IDLE, HOLD, FLUSH); stage index constants (STG_IF, STG_ID, STG_DISP, STG_EX).
- Sub-module stall_wdt: watchdog counter with sticky flag, parametrised by WDT_W.
- Arbitration and FSM live in the top module.

Test Plan:
- jump_req_i=2'b11, addr0=0x100, addr1=0x200, no stalls, FLUSH_LEN=1 -> same cycle: jump_flag_o=1, jump_addr_o=0x100, flush_o=4'hF; next cycle: flush_o=0.
- jump_req_i[1] with addr 0x80 while stall_ex_i=1 for 3 cycles -> jump_pending_o=1 for 3 cycles, jump_flag_o=0; cycle stall drops: jump_flag_o=1, addr 0x80.
- HOLD with pend 0x80, new req0 addr 0x40, then unblock -> redirect to 0x80 only; 0x40 never output.
- FLUSH_LEN=3, jump fires -> flush_o=4'hF for exactly 3 cycles; jump_req_i during cycles 2–3 ignored.
- stall_hdu_i=1, HDU_STAGE=1, no jump -> stall_o=4'b0011; same with jump_req_i -> stall_o=0, jump_flag_o=1.
- wdt_limit_i=5, stall_hdu_i held 8 cycles -> wdt_expired_o rises after cycle 6 and stays set; wdt_clr_i pulse -> 0. HOLD plus flush_clint_i -> pending cleared, jump_flag_o=0. rst=1 mid-HOLD -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the parametrised pipeline control unit.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } state_e;

  localparam int unsigned STG_IF   = 0;
  localparam int unsigned STG_ID   = 1;
  localparam int unsigned STG_DISP = 2;
  localparam int unsigned STG_EX   = 3;

endpackage

// File: rtl/stall_wdt.sv
// Stall watchdog: counts consecutive stalled cycles and raises a sticky
// flag when the count reaches a programmable, non-zero limit.
module stall_wdt
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned WDT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_i,
  input  logic [WDT_W-1:0] limit_i,
  input  logic             clr_i,
  output logic             expired_o
);

  logic [WDT_W-1:0] cnt_q, cnt_d;
  logic             exp_q, exp_d;

  always_comb begin
    cnt_d = '0;
    if (stall_i) cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    exp_d = exp_q;
    // Clear wins over a set landing on the same edge.
    if (clr_i)                                    exp_d = 1'b0;
    else if ((limit_i != '0) && (cnt_q == limit_i)) exp_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      exp_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      exp_q <= exp_d;
    end
  end

  assign expired_o = exp_q;

endmodule

// File: rtl/pipe_ctrl_gen.sv
// Pipeline control: jump arbitration with a pending-redirect buffer,
// multi-cycle flush window, per-stage stall generation and stall watchdog.
module pipe_ctrl_gen
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned NUM_JSRC   = 2,
  parameter int unsigned NUM_STAGES = 4,
  parameter int unsigned HDU_STAGE  = 1,
  parameter int unsigned FLUSH_LEN  = 1,
  parameter int unsigned WDT_W      = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_JSRC-1:0]        jump_req_i,
  input  logic [NUM_JSRC*ADDR_W-1:0] jump_addr_i,
  input  logic                       stall_ex_i,
  input  logic                       stall_clint_i,
  input  logic                       stall_hdu_i,
  input  logic                       atom_busy_i,
  input  logic                       flush_clint_i,
  input  logic [WDT_W-1:0]           wdt_limit_i,
  input  logic                       wdt_clr_i,
  output logic [NUM_STAGES-1:0]      stall_o,
  output logic [NUM_STAGES-1:0]      flush_o,
  output logic                       jump_flag_o,
  output logic [ADDR_W-1:0]          jump_addr_o,
  output logic                       jump_pending_o,
  output logic                       wdt_expired_o
);

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_LEN - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;

  logic              hard, block, req_any, fire;
  logic [ADDR_W-1:0] sel_addr, fire_addr;

  always_comb begin
    hard     = stall_ex_i | stall_clint_i;
    block    = hard | atom_busy_i;
    req_any  = 1'b0;
    sel_addr = '0;
    for (int unsigned i = 0; i < NUM_JSRC; i++) begin
      if (jump_req_i[i] && !req_any) begin
        req_any  = 1'b1;
        sel_addr = jump_addr_i[i*ADDR_W +: ADDR_W];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_addr_d = pend_addr_q;
    fire        = 1'b0;
    fire_addr   = '0;

    case (state_q)
      IDLE: begin
        if (req_any && !flush_clint_i) begin
          if (!block) begin
            fire      = 1'b1;
            fire_addr = sel_addr;
          end else begin
            pend_addr_d = sel_addr;
            state_d     = HOLD;
          end
        end
      end
      HOLD: begin
        if (!block && !flush_clint_i) begin
          fire      = 1'b1;
          fire_addr = pend_addr_q;
        end
      end
      FLUSH: begin
        // The redirect cycle itself supplies the first flush cycle.
        if (cnt_q <= 4'd1) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (fire) begin
      pend_addr_d = '0;
      if (FLUSH_LEN > 1) begin
        state_d = FLUSH;
        cnt_d   = FLUSH_INIT;
      end else begin
        state_d = IDLE;
      end
    end

    if (flush_clint_i) begin
      state_d     = IDLE;
      cnt_d       = '0;
      pend_addr_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pend_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_addr_q <= pend_addr_d;
    end
  end

  // Combinational outputs are gated by rst so reset forces them low at once.
  always_comb begin
    jump_flag_o    = fire & ~rst;
    jump_addr_o    = jump_flag_o ? fire_addr : '0;
    jump_pending_o = (state_q == HOLD) & ~rst;
    flush_o        = (!rst && (fire || flush_clint_i || state_q == FLUSH)) ? '1 : '0;
    for (int unsigned s = 0; s < NUM_STAGES; s++) begin
      stall_o[s] = ~rst & (hard | (stall_hdu_i & ~fire & (s <= HDU_STAGE)));
    end
  end

  stall_wdt #(
    .WDT_W(WDT_W)
  ) u_wdt (
    .clk      (clk),
    .rst      (rst),
    .stall_i  (hard | stall_hdu_i),
    .limit_i  (wdt_limit_i),
    .clr_i    (wdt_clr_i),
    .expired_o(wdt_expired_o)
  );

endmodule

// File: tb/tb_pipe_ctrl_gen.sv
// Bench for pipe_ctrl_gen: two instances (FLUSH_LEN 1 and 3) checked each
// cycle against a transaction-level model, plus directed literal checks.
module tb_pipe_ctrl_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  jreq;
  logic [63:0] jaddr;
  logic        sex, sclint, shdu, atom, fclint, wclr;
  logic [15:0] wlim;

  logic [3:0]  stall_o [2];
  logic [3:0]  flush_o [2];
  logic        jflag   [2];
  logic [31:0] jaddr_o [2];
  logic        jpend   [2];
  logic        wexp    [2];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipe_ctrl_gen #(.ADDR_W(32), .NUM_JSRC(2), .NUM_STAGES(4), .HDU_STAGE(1),
                  .FLUSH_LEN(1), .WDT_W(16)) dut1 (
    .clk(clk), .rst(rst), .jump_req_i(jreq), .jump_addr_i(jaddr),
    .stall_ex_i(sex), .stall_clint_i(sclint), .stall_hdu_i(shdu),
    .atom_busy_i(atom), .flush_clint_i(fclint), .wdt_limit_i(wlim),
    .wdt_clr_i(wclr), .stall_o(stall_o[0]), .flush_o(flush_o[0]),
    .jump_flag_o(jflag[0]), .jump_addr_o(jaddr_o[0]),
    .jump_pending_o(jpend[0]), .wdt_expired_o(wexp[0]));

  pipe_ctrl_gen #(.ADDR_W(32), .NUM_JSRC(2), .NUM_STAGES(4), .HDU_STAGE(1),
                  .FLUSH_LEN(3), .WDT_W(16)) dut3 (
    .clk(clk), .rst(rst), .jump_req_i(jreq), .jump_addr_i(jaddr),
    .stall_ex_i(sex), .stall_clint_i(sclint), .stall_hdu_i(shdu),
    .atom_busy_i(atom), .flush_clint_i(fclint), .wdt_limit_i(wlim),
    .wdt_clr_i(wclr), .stall_o(stall_o[1]), .flush_o(flush_o[1]),
    .jump_flag_o(jflag[1]), .jump_addr_o(jaddr_o[1]),
    .jump_pending_o(jpend[1]), .wdt_expired_o(wexp[1]));

  // Model state: held redirect, flush cycles still owed, stall run length.
  int          LEN [2] = '{1, 3};
  bit          pend_v [2];
  logic [31:0] pend_a [2];
  int          fl_left [2];
  int          wcnt [2];
  bit          wexp_m [2];
  bit          fire_m [2];
  logic [31:0] sel_m [2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      pend_v[d] = 0; pend_a[d] = '0; fl_left[d] = 0;
      wcnt[d] = 0; wexp_m[d] = 0; fire_m[d] = 0;
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      bit hard, blk, rany, f;
      logic [31:0] fa, sa;
      logic [3:0] ef, es;
      hard = sex | sclint;
      blk  = hard | atom;
      rany = |jreq;
      sa   = jreq[0] ? jaddr[31:0] : jaddr[63:32];
      f = 0; fa = '0;
      if (!rst && !fclint) begin
        if (pend_v[d]) begin
          if (!blk) begin f = 1; fa = pend_a[d]; end
        end else if (fl_left[d] == 0 && rany && !blk) begin
          f = 1; fa = sa;
        end
      end
      fire_m[d] = f;
      sel_m[d]  = sa;
      ef = (!rst && (f || fclint || fl_left[d] > 0)) ? 4'hF : 4'h0;
      for (int s = 0; s < 4; s++) es[s] = !rst && (hard || (shdu && !f && s <= 1));
      chk($sformatf("dut%0d jump_flag", d), {31'd0, jflag[d]}, {31'd0, f});
      chk($sformatf("dut%0d jump_addr", d), jaddr_o[d], fa);
      chk($sformatf("dut%0d flush", d), {28'd0, flush_o[d]}, {28'd0, ef});
      chk($sformatf("dut%0d stall", d), {28'd0, stall_o[d]}, {28'd0, es});
      chk($sformatf("dut%0d pending", d), {31'd0, jpend[d]}, {31'd0, (!rst && pend_v[d])});
      chk($sformatf("dut%0d wdt_expired", d), {31'd0, wexp[d]}, {31'd0, wexp_m[d]});
    end
  endtask

  task automatic update();
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        pend_v[d] = 0; pend_a[d] = '0; fl_left[d] = 0; wcnt[d] = 0; wexp_m[d] = 0;
      end else begin
        bit blk;
        blk = sex | sclint | atom;
        if (wclr) wexp_m[d] = 0;
        else if (wlim != 0 && wcnt[d] == int'(wlim)) wexp_m[d] = 1;
        if (sex || sclint || shdu) wcnt[d] = (wcnt[d] == 65535) ? 65535 : wcnt[d] + 1;
        else wcnt[d] = 0;
        if (fclint) begin
          pend_v[d] = 0; fl_left[d] = 0;
        end else if (fire_m[d]) begin
          pend_v[d] = 0; fl_left[d] = LEN[d] - 1;
        end else if (fl_left[d] > 0) begin
          fl_left[d]--;
        end else if (!pend_v[d] && (|jreq) && blk) begin
          pend_v[d] = 1; pend_a[d] = sel_m[d];
        end
      end
    end
  endtask

  task automatic settle();
    #1;
    check_all();
  endtask

  task automatic adv();
    @(posedge clk);
    update();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    jreq = '0; sex = 0; sclint = 0; shdu = 0; atom = 0; fclint = 0; wclr = 0;
  endtask

  initial begin
    model_reset();
    idle_inputs();
    jaddr = '0; wlim = '0;
    rst = 1; sex = 1; jreq = 2'b11; jaddr = {32'h200, 32'h100};
    settle();
    chk("reset jump_flag", {31'd0, jflag[0]}, 32'd0);
    chk("reset stall", {28'd0, stall_o[0]}, 32'd0);
    adv();
    rst = 0; idle_inputs();
    settle(); adv();

    // Both requesters: index 0 wins, single-cycle flush on dut1.
    jreq = 2'b11; jaddr = {32'h200, 32'h100};
    settle();
    chk("prio flag", {31'd0, jflag[0]}, 32'd1);
    chk("prio addr", jaddr_o[0], 32'h100);
    chk("prio flush", {28'd0, flush_o[0]}, 32'hF);
    adv(); jreq = '0;
    settle();
    chk("flush1 end", {28'd0, flush_o[0]}, 32'h0);
    repeat (3) begin adv(); settle(); end

    // Blocked by EX stall, released when stall drops.
    adv();
    jreq = 2'b10; jaddr = {32'h80, 32'h0}; sex = 1;
    settle();
    chk("block no flag", {31'd0, jflag[0]}, 32'd0);
    adv(); jreq = '0; settle();
    chk("hold pending", {31'd0, jpend[0]}, 32'd1);
    adv(); settle();
    chk("hold pending2", {31'd0, jpend[0]}, 32'd1);
    adv(); sex = 0; settle();
    chk("release flag", {31'd0, jflag[0]}, 32'd1);
    chk("release addr", jaddr_o[0], 32'h80);
    repeat (3) begin adv(); settle(); end

    // Held redirect beats a newer request.
    adv();
    jreq = 2'b10; jaddr = {32'h80, 32'h40}; sex = 1; settle();
    adv(); jreq = 2'b01; settle();
    chk("hold ignores req", {31'd0, jflag[0]}, 32'd0);
    adv(); sex = 0; settle();
    chk("oldest wins", jaddr_o[0], 32'h80);
    adv(); jreq = '0; settle();
    chk("new req dropped", {31'd0, jflag[0]}, 32'd0);
    repeat (3) begin adv(); settle(); end

    // FLUSH_LEN=3 window ignores requests.
    adv();
    jreq = 2'b01; jaddr = {32'h200, 32'h40}; settle();
    chk("len3 flush c1", {28'd0, flush_o[1]}, 32'hF);
    adv(); jreq = 2'b10; settle();
    chk("len3 flush c2", {28'd0, flush_o[1]}, 32'hF);
    chk("len3 ignore c2", {31'd0, jflag[1]}, 32'd0);
    adv(); settle();
    chk("len3 flush c3", {28'd0, flush_o[1]}, 32'hF);
    chk("len3 ignore c3", {31'd0, jflag[1]}, 32'd0);
    adv(); jreq = '0; settle();
    chk("len3 flush end", {28'd0, flush_o[1]}, 32'h0);
    repeat (3) begin adv(); settle(); end

    // Hazard stall pattern and jump override.
    adv();
    shdu = 1; settle();
    chk("hdu stall", {28'd0, stall_o[0]}, 32'h3);
    adv(); jreq = 2'b01; settle();
    chk("hdu masked", {28'd0, stall_o[0]}, 32'h0);
    chk("hdu jump", {31'd0, jflag[0]}, 32'd1);
    adv(); jreq = '0; shdu = 0; settle();
    repeat (3) begin adv(); settle(); end

    // Watchdog with limit 5 over an 8-cycle stall.
    adv();
    wlim = 16'd5; shdu = 1;
    for (int k = 1; k <= 8; k++) begin
      settle();
      chk($sformatf("wdt cycle %0d", k), {31'd0, wexp[0]}, {31'd0, (k >= 7)});
      adv();
    end
    shdu = 0; settle();
    chk("wdt sticky", {31'd0, wexp[0]}, 32'd1);
    adv(); wclr = 1; settle();
    adv(); wclr = 0; settle();
    chk("wdt cleared", {31'd0, wexp[0]}, 32'd0);

    // Interrupt flush while holding.
    adv();
    jreq = 2'b01; jaddr = {32'h0, 32'h44}; sex = 1; settle();
    adv(); jreq = '0; fclint = 1; settle();
    chk("clint no flag", {31'd0, jflag[0]}, 32'd0);
    chk("clint flush", {28'd0, flush_o[0]}, 32'hF);
    adv(); fclint = 0; sex = 0; settle();
    chk("clint pend clr", {31'd0, jpend[0]}, 32'd0);
    chk("clint no late jump", {31'd0, jflag[0]}, 32'd0);

    // Async reset mid-HOLD discards the pending redirect.
    adv();
    jreq = 2'b01; jaddr = {32'h0, 32'h48}; sex = 1; settle();
    adv(); jreq = '0; settle();
    chk("pre-rst pending", {31'd0, jpend[0]}, 32'd1);
    rst = 1; sex = 0;
    #1;
    model_reset();
    chk("rst async pending", {31'd0, jpend[0]}, 32'd0);
    chk("rst async flag", {31'd0, jflag[0]}, 32'd0);
    chk("rst async flush", {28'd0, flush_o[0]}, 32'd0);
    check_all();
    adv(); rst = 0; settle();
    chk("post-rst no jump", {31'd0, jflag[0]}, 32'd0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      adv();
      jreq   = 2'($urandom);
      jaddr  = {$urandom, $urandom};
      sex    = ($urandom_range(0, 3) == 0);
      sclint = ($urandom_range(0, 7) == 0);
      shdu   = ($urandom_range(0, 3) == 0);
      atom   = ($urandom_range(0, 5) == 0);
      fclint = ($urandom_range(0, 15) == 0);
      wclr   = ($urandom_range(0, 19) == 0);
      if (n % 64 == 0) wlim = 16'($urandom_range(0, 6));
      rst    = ($urandom_range(0, 299) == 0);
      if (rst) begin #1; model_reset(); #0; end
      settle();
    end
    adv();
    rst = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
